// File: rtl/seg_counter_ctrl_if.sv
// seg_counter_ctrl_if
//   Groups the button inputs and display outputs of seg_counter_ctrl.
//   master : drives the raw buttons, observes the display digits and pulses
//   slave  : the counter controller itself
// Signals:
//   i_Inc_Switch  raw increment button, active-high, asynchronous
//   i_Clr_Switch  raw clear button, active-high, asynchronous
//   o_Ones_Bcd    ones digit 0-9
//   o_Tens_Bcd    tens digit 0-9
//   o_Tens_Blank  high while the tens digit is 0
//   o_Count_Pulse one-cycle pulse per increment
//   o_Wrap_Pulse  one-cycle pulse on the 99 -> 00 increment
interface seg_counter_ctrl_if;
    logic       i_Inc_Switch;
    logic       i_Clr_Switch;
    logic [3:0] o_Ones_Bcd;
    logic [3:0] o_Tens_Bcd;
    logic       o_Tens_Blank;
    logic       o_Count_Pulse;
    logic       o_Wrap_Pulse;

    modport master (
        output i_Inc_Switch, i_Clr_Switch,
        input  o_Ones_Bcd, o_Tens_Bcd, o_Tens_Blank, o_Count_Pulse, o_Wrap_Pulse
    );

    modport slave (
        input  i_Inc_Switch, i_Clr_Switch,
        output o_Ones_Bcd, o_Tens_Bcd, o_Tens_Blank, o_Count_Pulse, o_Wrap_Pulse
    );
endinterface

// File: rtl/seg_counter_ctrl.sv
// seg_counter_ctrl
//   Turns two raw push buttons into a two-digit BCD count (00-99): each button
//   is synchronised and debounced, increment presses are edge-detected and
//   auto-repeat while held, and the clear button forces the count to 00.
// Ports:
//   i_Clk    system clock, rising edge
//   i_Rst_L  asynchronous active-low reset
//   bus      seg_counter_ctrl_if.slave (buttons in, digits/blank/pulses out)
// Parameters:
//   DEBOUNCE_LIMIT  cycles a synchronised input must differ before it is accepted
//   REPEAT_DELAY    cycles from a press increment to the first repeat increment
//   REPEAT_PERIOD   cycles between later repeat increments

// Per-button synchroniser + debouncer.
//   i_Raw  asynchronous button level
//   o_Deb  debounced level
module seg_counter_ctrl_db #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Raw,
    output logic o_Deb
);
    localparam int DB_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LIMIT - 1);

    logic [1:0]      r_sync;
    logic [DB_W-1:0] r_cnt;
    logic            r_deb;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_deb  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_Raw};
            // Any cycle where the synchronised level agrees with the accepted
            // level restarts the count, so short glitches never accumulate.
            if (r_sync[1] == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_LAST) begin
                r_deb <= ~r_deb;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_Deb = r_deb;
endmodule

module seg_counter_ctrl #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int REPEAT_DELAY   = 12500000,
    parameter int REPEAT_PERIOD  = 2500000
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    seg_counter_ctrl_if.slave   bus
);
    localparam int NUM_SW  = 2;
    localparam int SW_INC  = 0;
    localparam int SW_CLR  = 1;
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } state_t;

    logic [NUM_SW-1:0] w_raw;
    logic [NUM_SW-1:0] w_deb;
    logic              w_inc_deb;
    logic              w_clr_deb;

    state_t            r_state, w_state_nxt;
    logic [TMR_W-1:0]  r_timer, w_timer_nxt;
    logic              r_inc_prev;
    logic              w_inc;
    logic [3:0]        r_ones, r_tens;
    logic              r_count_pulse, r_wrap_pulse;

    assign w_raw = {bus.i_Clr_Switch, bus.i_Inc_Switch};

    seg_counter_ctrl_db #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_db [NUM_SW-1:0] (
        .i_Clk  (i_Clk),
        .i_Rst_L(i_Rst_L),
        .i_Raw  (w_raw),
        .o_Deb  (w_deb)
    );

    assign w_inc_deb = w_deb[SW_INC];
    assign w_clr_deb = w_deb[SW_CLR];

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_inc_prev <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            // Tracked even during clear, so an inc held through a clear
            // release is not seen as a fresh press.
            r_inc_prev <= w_inc_deb;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_inc       = 1'b0;
        if (w_clr_deb) begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_inc_deb && !r_inc_prev) begin
                        w_inc       = 1'b1;
                        w_timer_nxt = '0;
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!w_inc_deb) begin
                        w_state_nxt = ST_IDLE;
                        w_timer_nxt = '0;
                    end else if (r_timer == DELAY_LAST) begin
                        w_inc       = 1'b1;
                        w_timer_nxt = '0;
                        w_state_nxt = ST_REPEAT;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!w_inc_deb) begin
                        w_state_nxt = ST_IDLE;
                        w_timer_nxt = '0;
                    end else if (r_timer == PERIOD_LAST) begin
                        w_inc       = 1'b1;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    // BCD digits and pulses; w_inc is already suppressed while clearing.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_ones        <= '0;
            r_tens        <= '0;
            r_count_pulse <= 1'b0;
            r_wrap_pulse  <= 1'b0;
        end else begin
            r_count_pulse <= w_inc;
            r_wrap_pulse  <= w_inc && (r_ones == 4'd9) && (r_tens == 4'd9);
            if (w_clr_deb) begin
                r_ones <= '0;
                r_tens <= '0;
            end else if (w_inc) begin
                if (r_ones == 4'd9) begin
                    r_ones <= '0;
                    r_tens <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
                end else begin
                    r_ones <= r_ones + 4'd1;
                end
            end
        end
    end

    assign bus.o_Ones_Bcd    = r_ones;
    assign bus.o_Tens_Bcd    = r_tens;
    assign bus.o_Tens_Blank  = (r_tens == 4'd0);
    assign bus.o_Count_Pulse = r_count_pulse;
    assign bus.o_Wrap_Pulse  = r_wrap_pulse;
endmodule
